// File: rtl/spi_pkg.sv
// Shared types and helpers for the burst-capable SPI front end.
// Command word layout: R/W flag first, then the address MSB first.
package spi_pkg;

  typedef enum logic [1:0] {
    CMD,
    WDATA,
    TURN,
    RDATA
  } spi_state_t;

  localparam int unsigned RW_BIT_FIRST = 1;

  function automatic int unsigned cmd_w(input int unsigned addr_w);
    return addr_w + RW_BIT_FIRST;
  endfunction

endpackage

// File: rtl/spi_shift_param.sv
// Generic MSB-first shift register with synchronous clear, parallel load and serial in/out.
// Priority: reset, clear, load, shift.
module spi_shift_param #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         shift_i,
  input  logic         sin_i,
  output logic [W-1:0] q_o,
  output logic         sout_o
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = {q_q[W-2:0], sin_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o    = q_q;
  assign sout_o = q_q[W-1];

endmodule

// File: rtl/spi_frontend_burst.sv
// SPI front end: command word (R/W + address) followed by a gapless burst of data words,
// either written to the register file or read back serially on poci.
module spi_frontend_burst
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic              spi_clk,
  input  logic              rstn,
  input  logic              cs,
  input  logic              pico,
  input  logic [DATA_W-1:0] rdata,
  output logic              poci,
  output logic              is_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              wr_en,
  output logic              rd_en
);

  localparam int unsigned CmdW = cmd_w(ADDR_W);
  localparam int unsigned InW  = (CmdW > DATA_W) ? CmdW : DATA_W;
  localparam int unsigned CntW = $clog2(InW);

  spi_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_write_q, is_write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;

  logic              in_clr, in_shift;
  logic [InW-1:0]    in_q, in_next;
  logic              in_sout;
  logic              out_clr, out_load, out_shift;
  logic [DATA_W-1:0] out_q;
  logic              out_sout;
  logic              unused_ok;

  spi_shift_param #(
    .W (InW)
  ) u_in_shift (
    .clk_i      (spi_clk),
    .rst_ni     (rstn),
    .clr_i      (in_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .shift_i    (in_shift),
    .sin_i      (pico),
    .q_o        (in_q),
    .sout_o     (in_sout)
  );

  spi_shift_param #(
    .W (DATA_W)
  ) u_out_shift (
    .clk_i      (spi_clk),
    .rst_ni     (rstn),
    .clr_i      (out_clr),
    .load_i     (out_load),
    .load_val_i (rdata),
    .shift_i    (out_shift),
    .sin_i      (1'b0),
    .q_o        (out_q),
    .sout_o     (out_sout)
  );

  // Word as it will stand once the bit on pico is captured at this edge.
  assign in_next   = {in_q[InW-2:0], pico};
  assign unused_ok = ^{in_sout, out_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    is_write_d = is_write_q;
    wdata_d    = wdata_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    in_clr     = 1'b0;
    in_shift   = 1'b0;
    out_clr    = 1'b0;
    out_load   = 1'b0;
    out_shift  = 1'b0;

    // A completed write word advances the address even if the frame ends here.
    if ((AUTO_INC != 0) && wr_en_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end

    if (cs) begin
      state_d = CMD;
      cnt_d   = '0;
      in_clr  = 1'b1;
      out_clr = 1'b1;
    end else begin
      unique case (state_q)
        CMD: begin
          in_shift = 1'b1;
          if (cnt_q == CntW'(CmdW - 1)) begin
            cnt_d      = '0;
            is_write_d = in_next[CmdW-1];
            addr_d     = in_next[ADDR_W-1:0];
            state_d    = in_next[CmdW-1] ? WDATA : TURN;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        WDATA: begin
          in_shift = 1'b1;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            cnt_d   = '0;
            wdata_d = in_next[DATA_W-1:0];
            wr_en_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        TURN: begin
          out_load = 1'b1;
          cnt_d    = '0;
          state_d  = RDATA;
        end
        RDATA: begin
          if (cnt_q == CntW'(DATA_W - 1)) begin
            out_load = 1'b1;
            cnt_d    = '0;
          end else begin
            out_shift = 1'b1;
            cnt_d     = cnt_q + CntW'(1);
          end
        end
      endcase

      // Request the next word while its predecessor's last bit is on poci.
      if ((state_d == RDATA) && (cnt_d == CntW'(DATA_W - 1))) begin
        rd_en_d = 1'b1;
        if (AUTO_INC != 0) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end else if (state_d == TURN) begin
        rd_en_d = 1'b1;
      end
    end
  end

  always_ff @(posedge spi_clk) begin
    if (!rstn) begin
      state_q    <= CMD;
      cnt_q      <= '0;
      addr_q     <= '0;
      is_write_q <= 1'b0;
      wdata_q    <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      is_write_q <= is_write_d;
      wdata_q    <= wdata_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
    end
  end

  assign poci     = out_sout;
  assign is_write = is_write_q;
  assign addr     = addr_q;
  assign wdata    = wdata_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;

endmodule

// File: tb/tb_spi_frontend_burst.sv
// Bench for spi_frontend_burst: one auto-increment and one fixed-address instance share stimulus;
// a frame-level model predicts every output each cycle, plus literal spot checks.
module tb_spi_frontend_burst;

  logic       spi_clk = 1'b0;
  logic       rstn;
  logic       cs;
  logic       pico;
  logic [7:0] rdata_a [2];
  logic       poci_a  [2];
  logic       isw_a   [2];
  logic [6:0] addr_a  [2];
  logic [7:0] wdata_a [2];
  logic       wr_a    [2];
  logic       rd_a    [2];

  always #5 spi_clk = ~spi_clk;

  assign rdata_a[0] = {1'b0, addr_a[0]} ^ 8'hFF;
  assign rdata_a[1] = {1'b0, addr_a[1]} ^ 8'hFF;

  spi_frontend_burst #(
    .ADDR_W   (7),
    .DATA_W   (8),
    .AUTO_INC (1)
  ) u_dut_inc (
    .spi_clk  (spi_clk),
    .rstn     (rstn),
    .cs       (cs),
    .pico     (pico),
    .rdata    (rdata_a[0]),
    .poci     (poci_a[0]),
    .is_write (isw_a[0]),
    .addr     (addr_a[0]),
    .wdata    (wdata_a[0]),
    .wr_en    (wr_a[0]),
    .rd_en    (rd_a[0])
  );

  spi_frontend_burst #(
    .ADDR_W   (7),
    .DATA_W   (8),
    .AUTO_INC (0)
  ) u_dut_hold (
    .spi_clk  (spi_clk),
    .rstn     (rstn),
    .cs       (cs),
    .pico     (pico),
    .rdata    (rdata_a[1]),
    .poci     (poci_a[1]),
    .is_write (isw_a[1]),
    .addr     (addr_a[1]),
    .wdata    (wdata_a[1]),
    .wr_en    (wr_a[1]),
    .rd_en    (rd_a[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_pulses [2];

  // Current frame as the stimulus intends it.
  logic       d_write;
  logic [6:0] d_base;
  logic [7:0] d_words [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_desc(input logic w, input logic [6:0] base, input logic [7:0] w0,
                          input logic [7:0] w1, input logic [7:0] w2);
    d_write    = w;
    d_base     = base;
    d_words[0] = w0;
    d_words[1] = w1;
    d_words[2] = w2;
    d_words[3] = 8'h00;
    wr_pulses[0] = 0;
    wr_pulses[1] = 0;
  endtask

  task automatic idle(input int n);
    cs   = 1'b1;
    pico = 1'b0;
    repeat (n) begin
      @(posedge spi_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      cs   = 1'b0;
      pico = v[k];
      @(posedge spi_clk);
      #1;
    end
  endtask

  task automatic read_word(output logic [7:0] v);
    for (int k = 7; k >= 0; k--) begin
      v[k] = poci_a[0];
      cs   = 1'b0;
      pico = 1'($urandom_range(0, 1));
      @(posedge spi_clk);
      #1;
    end
  endtask

  // Frame-level model: edges since cs fell decide which bit/word is on the wire.
  initial begin : model
    int         ecnt;
    int         m, j, wi, b, inc;
    logic       r, c;
    logic       ew, er, ep;
    logic [6:0] a;
    logic [7:0] rv;
    logic [6:0] m_addr  [2];
    logic       m_isw   [2];
    logic [7:0] m_wdata [2];
    logic       prev_wr [2];
    ecnt = 0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_isw[i] = 1'b0; m_wdata[i] = '0; prev_wr[i] = 1'b0;
    end
    forever begin
      @(posedge spi_clk);
      r = rstn;
      c = cs;
      #2;
      if (!r || c) ecnt = 0;
      else ecnt++;
      for (int i = 0; i < 2; i++) begin
        inc = (i == 0) ? 1 : 0;
        ew = 1'b0; er = 1'b0; ep = 1'b0;
        if (!r) begin
          m_addr[i] = '0; m_isw[i] = 1'b0; m_wdata[i] = '0;
        end else begin
          if (prev_wr[i]) m_addr[i] = m_addr[i] + 7'(inc);
          if (!c) begin
            if (ecnt == 8) begin
              m_isw[i]  = d_write;
              m_addr[i] = d_base;
              er        = !d_write;
            end else if (ecnt > 8 && d_write) begin
              m = ecnt - 8;
              if (m % 8 == 0) begin
                ew         = 1'b1;
                m_wdata[i] = d_words[m/8-1];
              end
            end else if (ecnt > 8) begin
              j  = ecnt - 9;
              wi = j / 8;
              b  = j % 8;
              a  = d_base + 7'(wi * inc);
              rv = {1'b0, a} ^ 8'hFF;
              ep = rv[7-b];
              if (b == 7) begin
                er        = 1'b1;
                m_addr[i] = d_base + 7'((wi + 1) * inc);
              end
            end
          end
        end
        prev_wr[i] = ew;
        if (wr_a[i]) wr_pulses[i]++;
        check($sformatf("dut%0d wr_en e=%0d", i, ecnt), 32'(wr_a[i]), 32'(ew));
        check($sformatf("dut%0d rd_en e=%0d", i, ecnt), 32'(rd_a[i]), 32'(er));
        check($sformatf("dut%0d poci e=%0d", i, ecnt), 32'(poci_a[i]), 32'(ep));
        check($sformatf("dut%0d addr e=%0d", i, ecnt), 32'(addr_a[i]), 32'(m_addr[i]));
        check($sformatf("dut%0d is_write e=%0d", i, ecnt), 32'(isw_a[i]), 32'(m_isw[i]));
        check($sformatf("dut%0d wdata e=%0d", i, ecnt), 32'(wdata_a[i]), 32'(m_wdata[i]));
      end
    end
  end

  initial begin : stim
    logic [7:0] w0, w1;
    rstn = 1'b0;
    cs   = 1'b1;
    pico = 1'b0;
    set_desc(1'b0, 7'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) begin
      @(posedge spi_clk);
      #1;
    end
    check("reset addr", 32'(addr_a[0]), 32'h0);
    check("reset wdata", 32'(wdata_a[0]), 32'h0);
    check("reset is_write", 32'(isw_a[0]), 32'h0);
    check("reset poci", 32'(poci_a[0]), 32'h0);
    rstn = 1'b1;
    idle(1);

    // Reset lands mid-word while cs is still low.
    set_desc(1'b1, 7'h0A, 8'h00, 8'h00, 8'h00);
    send(8'h8A, 8);
    check("t1 addr before reset", 32'(addr_a[0]), 32'h0A);
    send(8'hFF, 5);
    rstn = 1'b0;
    cs   = 1'b0;
    pico = 1'b1;
    @(posedge spi_clk);
    #1;
    check("t1 addr after reset", 32'(addr_a[0]), 32'h0);
    check("t1 is_write after reset", 32'(isw_a[0]), 32'h0);
    check("t1 wr_en after reset", 32'(wr_a[0]), 32'h0);
    rstn = 1'b1;
    idle(1);

    // Single write word.
    set_desc(1'b1, 7'h05, 8'hA5, 8'h00, 8'h00);
    send(8'h85, 8);
    send(8'hA5, 8);
    check("t2 wr_en", 32'(wr_a[0]), 32'h1);
    check("t2 addr", 32'(addr_a[0]), 32'h05);
    check("t2 wdata", 32'(wdata_a[0]), 32'hA5);
    idle(1);
    check("t2 addr incremented", 32'(addr_a[0]), 32'h06);
    check("t2 addr held", 32'(addr_a[1]), 32'h05);

    // Burst across the address wrap.
    set_desc(1'b1, 7'h7F, 8'h11, 8'h22, 8'h33);
    send(8'hFF, 8);
    send(8'h11, 8);
    send(8'h22, 8);
    send(8'h33, 8);
    idle(1);
    check("t3 wr pulses", 32'(wr_pulses[0]), 32'd3);
    check("t3 addr wrapped", 32'(addr_a[0]), 32'h02);
    check("t3 last wdata", 32'(wdata_a[0]), 32'h33);

    // Two-word burst read.
    set_desc(1'b0, 7'h10, 8'h00, 8'h00, 8'h00);
    send(8'h10, 8);
    check("t4 turn rd_en", 32'(rd_a[0]), 32'h1);
    check("t4 turn addr", 32'(addr_a[0]), 32'h10);
    check("t4 turn poci", 32'(poci_a[0]), 32'h0);
    cs   = 1'b0;
    pico = 1'b1;
    @(posedge spi_clk);
    #1;
    read_word(w0);
    read_word(w1);
    check("t4 read word0", 32'(w0), 32'hEF);
    check("t4 read word1", 32'(w1), 32'hEE);
    idle(1);

    // Frame aborted three bits into the second word.
    set_desc(1'b1, 7'h30, 8'h5A, 8'h00, 8'h00);
    send(8'hB0, 8);
    send(8'h5A, 8);
    send(8'h05, 3);
    idle(1);
    check("t5 wr pulses", 32'(wr_pulses[0]), 32'd1);
    check("t5 addr inc", 32'(addr_a[0]), 32'h31);
    check("t5 addr hold", 32'(addr_a[1]), 32'h30);

    // Fixed-address burst on the AUTO_INC=0 instance.
    set_desc(1'b1, 7'h20, 8'h01, 8'h02, 8'h00);
    send(8'hA0, 8);
    send(8'h01, 8);
    send(8'h02, 8);
    check("t6 second wr_en", 32'(wr_a[1]), 32'h1);
    check("t6 second addr", 32'(addr_a[1]), 32'h20);
    idle(1);
    check("t6 wr pulses", 32'(wr_pulses[1]), 32'd2);
    check("t6 addr held", 32'(addr_a[1]), 32'h20);
    check("t6 last wdata", 32'(wdata_a[1]), 32'h02);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
